coriolis_ker0_join2: RTL and testbench

Two-input stream join stage placed directly upstream of a two-operand leaf node (e.g. the single-precision subtract node), feeding its `in1_s0`/`in2_s0` operands. It absorbs arrival skew between the two operand streams in independent per-input FIFOs and presents an operand pair to the downstream node only when both are available. It applies valid/ready handshakes on every port, so upstream producers stall independently when their own FIFO fills.

---
 rtl/coriolis_ker0_join2_if.sv | 26 ++
 rtl/coriolis_ker0_join2.sv | 76 +++++++
 tb/tb_coriolis_ker0_join2.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/coriolis_ker0_join2_if.sv
// Handshake bundle for the two-operand join stage: two producer streams in,
// one paired operand stream out.
interface coriolis_ker0_join2_if #(
    parameter int STREAMW = 34
);
    logic               ivalid_in1_s0;
    logic [STREAMW-1:0] in1_s0;
    logic               iready_in1_s0;
    logic               ivalid_in2_s0;
    logic [STREAMW-1:0] in2_s0;
    logic               iready_in2_s0;
    logic [STREAMW-1:0] out1_s0;
    logic [STREAMW-1:0] out2_s0;
    logic               ovalid;
    logic               oready;

    modport master (
        output ivalid_in1_s0, in1_s0, ivalid_in2_s0, in2_s0, oready,
        input  iready_in1_s0, iready_in2_s0, out1_s0, out2_s0, ovalid
    );

    modport slave (
        input  ivalid_in1_s0, in1_s0, ivalid_in2_s0, in2_s0, oready,
        output iready_in1_s0, iready_in2_s0, out1_s0, out2_s0, ovalid
    );
endinterface

// File: rtl/coriolis_ker0_join2.sv
// Two-input stream join: per-input FWFT FIFOs absorb arrival skew and release
// an operand pair only when both heads are present.
module coriolis_ker0_join2 #(
    parameter int STREAMW = 34,
    parameter int DEPTH   = 4,
    parameter int ADDRW   = 2
) (
    input logic clk,
    input logic rst,
    coriolis_ker0_join2_if.slave bus
);
    localparam logic [ADDRW:0] CNT_FULL = (ADDRW + 1)'(DEPTH);

    logic [STREAMW-1:0] mem    [2][DEPTH];
    logic [ADDRW-1:0]   wr_ptr [2];
    logic [ADDRW-1:0]   rd_ptr [2];
    logic [ADDRW:0]     cnt    [2];
    logic [STREAMW-1:0] din    [2];
    logic [STREAMW-1:0] head   [2];
    logic [1:0]         ivalid;
    logic [1:0]         iready;
    logic [1:0]         nonempty;
    logic [1:0]         push;
    logic               pop;

    assign din[0]    = bus.in1_s0;
    assign din[1]    = bus.in2_s0;
    assign ivalid[0] = bus.ivalid_in1_s0;
    assign ivalid[1] = bus.ivalid_in2_s0;

    // Ready comes from the registered count only, so a full FIFO stays
    // closed during the cycle it is popped.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            iready[k]   = (cnt[k] != CNT_FULL);
            nonempty[k] = (cnt[k] != '0);
            push[k]     = ivalid[k] & iready[k];
            head[k]     = nonempty[k] ? mem[k][rd_ptr[k]] : '0;
        end
    end

    assign pop               = (&nonempty) & bus.oready;
    assign bus.ovalid        = &nonempty;
    assign bus.iready_in1_s0 = iready[0];
    assign bus.iready_in2_s0 = iready[1];
    assign bus.out1_s0       = head[0];
    assign bus.out2_s0       = head[1];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop)     rd_ptr[k] <= rd_ptr[k] + 1'b1;
                case ({push[k], pop})
                    2'b10:   cnt[k] <= cnt[k] + 1'b1;
                    2'b01:   cnt[k] <= cnt[k] - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: storage is not reset; zeroed counts make stale entries invisible.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst && push[k]) mem[k][wr_ptr[k]] <= din[k];
        end
    end
endmodule

// File: tb/tb_coriolis_ker0_join2.sv
// Directed bench for coriolis_ker0_join2: reset, aligned, skew, backpressure,
// full-with-pop and mid-stream reset scenarios with hand-computed expectations.
module tb_coriolis_ker0_join2;
    localparam int STREAMW = 34;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    coriolis_ker0_join2_if #(.STREAMW(STREAMW)) bus ();

    coriolis_ker0_join2 #(.STREAMW(STREAMW), .DEPTH(4), .ADDRW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [STREAMW-1:0] d1,
                         input logic v2, input logic [STREAMW-1:0] d2,
                         input logic ordy);
        bus.ivalid_in1_s0 = v1;
        bus.in1_s0        = d1;
        bus.ivalid_in2_s0 = v2;
        bus.in2_s0        = d2;
        bus.oready        = ordy;
    endtask

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b0);

        // Reset held for two cycles
        tick();
        tick();
        check("rst_ovalid", 64'(bus.ovalid), 64'd0);
        check("rst_iready1", 64'(bus.iready_in1_s0), 64'd1);
        check("rst_iready2", 64'(bus.iready_in2_s0), 64'd1);
        check("rst_out1", 64'(bus.out1_s0), 64'd0);
        check("rst_out2", 64'(bus.out2_s0), 64'd0);

        // Idle after release
        rst = 1'b1;
        tick();
        tick();
        check("idle_ovalid", 64'(bus.ovalid), 64'd0);
        check("idle_iready1", 64'(bus.iready_in1_s0), 64'd1);
        check("idle_out1", 64'(bus.out1_s0), 64'd0);

        // Aligned streams, one pair per cycle
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, STREAMW'(i), 1'b1, STREAMW'(i * 10), 1'b1);
            tick();
            check("align_ovalid", 64'(bus.ovalid), 64'd1);
            check("align_out1", 64'(bus.out1_s0), 64'(i));
            check("align_out2", 64'(bus.out2_s0), 64'(i * 10));
            check("align_iready1", 64'(bus.iready_in1_s0), 64'd1);
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        check("align_drain_ovalid", 64'(bus.ovalid), 64'd0);
        check("align_drain_out1", 64'(bus.out1_s0), 64'd0);

        // Skew: five attempts on in1, only four fit
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, STREAMW'(100 + i), 1'b0, '0, 1'b1);
            tick();
            check("skew_ovalid", 64'(bus.ovalid), 64'd0);
            check("skew_out2", 64'(bus.out2_s0), 64'd0);
        end
        check("skew_iready1", 64'(bus.iready_in1_s0), 64'd0);
        check("skew_out1", 64'(bus.out1_s0), 64'd100);
        drive(1'b0, '0, 1'b1, 34'd7, 1'b1);
        tick();
        check("skew_pair_ovalid", 64'(bus.ovalid), 64'd1);
        check("skew_pair_out1", 64'(bus.out1_s0), 64'd100);
        check("skew_pair_out2", 64'(bus.out2_s0), 64'd7);

        // Fill in2 with oready low
        for (int i = 8; i <= 10; i++) begin
            drive(1'b0, '0, 1'b1, STREAMW'(i), 1'b0);
            tick();
        end
        check("fill_iready1", 64'(bus.iready_in1_s0), 64'd0);
        check("fill_iready2", 64'(bus.iready_in2_s0), 64'd0);

        // Backpressure: both full, pushes attempted, nothing moves
        drive(1'b1, 34'h999, 1'b1, 34'h888, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_ovalid", 64'(bus.ovalid), 64'd1);
            check("bp_out1", 64'(bus.out1_s0), 64'd100);
            check("bp_out2", 64'(bus.out2_s0), 64'd7);
            check("bp_iready1", 64'(bus.iready_in1_s0), 64'd0);
        end

        // Full with push attempt and pop in the same cycle
        drive(1'b1, 34'd200, 1'b1, 34'd300, 1'b1);
        tick();
        check("fullpop_out1", 64'(bus.out1_s0), 64'd101);
        check("fullpop_out2", 64'(bus.out2_s0), 64'd8);
        check("fullpop_iready1", 64'(bus.iready_in1_s0), 64'd1);
        check("fullpop_iready2", 64'(bus.iready_in2_s0), 64'd1);
        tick();
        check("retry_out1", 64'(bus.out1_s0), 64'd102);
        check("retry_out2", 64'(bus.out2_s0), 64'd9);
        check("retry_iready1", 64'(bus.iready_in1_s0), 64'd1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        check("drain3_out1", 64'(bus.out1_s0), 64'd103);
        check("drain3_out2", 64'(bus.out2_s0), 64'd10);
        tick();
        check("drain4_out1", 64'(bus.out1_s0), 64'd200);
        check("drain4_out2", 64'(bus.out2_s0), 64'd300);
        tick();
        check("drain_empty_ovalid", 64'(bus.ovalid), 64'd0);
        check("drain_empty_out1", 64'(bus.out1_s0), 64'd0);

        // Mid-stream reset discards queued words and blocks the reset-cycle push
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, STREAMW'(16 + i), 1'b1, STREAMW'(32 + i), 1'b0);
            tick();
        end
        check("mid_ovalid", 64'(bus.ovalid), 64'd1);
        check("mid_out1", 64'(bus.out1_s0), 64'h11);
        check("mid_out2", 64'(bus.out2_s0), 64'h21);
        drive(1'b1, 34'h55, 1'b1, 34'h66, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("mrst_ovalid", 64'(bus.ovalid), 64'd0);
        check("mrst_iready1", 64'(bus.iready_in1_s0), 64'd1);
        check("mrst_out1", 64'(bus.out1_s0), 64'd0);
        check("mrst_out2", 64'(bus.out2_s0), 64'd0);
        tick();
        check("mrst_idle_ovalid", 64'(bus.ovalid), 64'd0);
        drive(1'b1, 34'h31, 1'b1, 34'h41, 1'b1);
        tick();
        check("fresh_ovalid", 64'(bus.ovalid), 64'd1);
        check("fresh_out1", 64'(bus.out1_s0), 64'h31);
        check("fresh_out2", 64'(bus.out2_s0), 64'h41);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        tick();
        check("fresh_drain_ovalid", 64'(bus.ovalid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
